// File: rtl/mem_access_controller.sv
// Memory-stage controller: runs each 32-bit load/store as two 16-bit SRAM
// phases (low half-word, then high half-word) with WAIT_CYCLES cycles per
// phase, and holds ready low so the pipeline freezes until the access ends.
// Optional build macro: MEM_POSTED_WRITE_EN. When defined, writes complete in
// the background without freezing the pipeline; reads still stall.
module mem_access_controller #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       ST_val,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]       SRAM_DQ_out,
    input  logic [15:0]       SRAM_DQ_in,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_WE_N
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] off;
    logic [31:0] data;
    logic        op_write;
    logic        req;
    logic        in_phase;

    // Only the half-word index bits of the offset reach the SRAM; the rest
    // (byte lane bits and anything above the SRAM size) wrap away silently.
    logic unused_off;
    assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};

    assign req      = MEM_R_EN | MEM_W_EN;
    assign in_phase = (state == LOW) || (state == HIGH);

    // Sequencer: latch the operands on acceptance, then count out each phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            off       <= 32'd0;
            data      <= 32'd0;
            op_write  <= 1'b0;
            read_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        off      <= ALU_result - 32'(BASE_ADDR);
                        data     <= ST_val;
                        op_write <= MEM_W_EN;
                        cnt      <= 4'd0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        if (!op_write) begin
                            read_data[15:0] <= SRAM_DQ_in;
                        end
                        cnt   <= 4'd0;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        if (!op_write) begin
                            read_data[31:16] <= SRAM_DQ_in;
                        end
                        cnt <= 4'd0;
`ifdef MEM_POSTED_WRITE_EN
                        state <= op_write ? IDLE : DONE;
`else
                        state <= DONE;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM bus: address/data follow the phase; write strobe drops on the last
    // cycle of each phase so address and data are held past the strobe edge.
    always_comb begin
        SRAM_ADDR   = '0;
        SRAM_DQ_out = 16'd0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        if (in_phase) begin
            SRAM_ADDR   = {off[ADDR_W:2], (state == HIGH)};
            SRAM_DQ_out = (state == HIGH) ? data[31:16] : data[15:0];
            if (op_write) begin
                SRAM_DQ_oe = 1'b1;
                SRAM_WE_N  = (cnt == LAST);
            end
        end
    end

    // Stall control: the pipeline is frozen whenever ready is low.
    always_comb begin
`ifdef MEM_POSTED_WRITE_EN
        ready = ((state == IDLE) && (!req || MEM_W_EN))
              || (state == DONE)
              || (in_phase && op_write && !req);
`else
        ready = ((state == IDLE) && !req) || (state == DONE);
`endif
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: a transaction-level model
// (cycle offset since acceptance plus a reference half-word store) is checked
// against the DUT every cycle, alongside hand-computed directed expectations.
module tb_mem_access_controller;

    localparam int ADDR_W = 18;
    localparam int W      = 5;
    localparam int BASE   = 1024;

`ifdef MEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       alu_result;
    logic [31:0]       st_val;
    logic [31:0]       read_data;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic [15:0]       sram_dq_in;
    logic              sram_dq_oe;
    logic              sram_we_n;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    mem_access_controller #(
        .ADDR_W(ADDR_W), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .ALU_result(alu_result), .ST_val(st_val), .read_data(read_data),
        .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_DQ_out(sram_dq_out),
        .SRAM_DQ_in(sram_dq_in), .SRAM_DQ_oe(sram_dq_oe), .SRAM_WE_N(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device: asynchronous read, write taken at each edge with WE_N low.
    logic [15:0] sram [0:1023];
    initial for (int i = 0; i < 1024; i++) sram[i] = 16'd0;
    assign sram_dq_in = sram[sram_addr[9:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram[sram_addr[9:0]] <= sram_dq_out;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Transaction-level reference model.
    int          mk = -1;
    bit          m_write;
    logic [31:0] m_hw;
    logic [31:0] m_data;
    logic [31:0] exp_rd = 32'd0;
    logic [15:0] ref_mem [0:1023];
    initial for (int i = 0; i < 1024; i++) ref_mem[i] = 16'd0;

    // Advance the model at each active edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (rst) begin
            mk     = -1;
            exp_rd = 32'd0;
        end else if (mk < 0) begin
            if (mem_r_en || mem_w_en) begin
                m_write = mem_w_en;
                m_hw    = (((alu_result - BASE) / 4) * 2) % (32'd1 << ADDR_W);
                m_data  = st_val;
                mk      = 1;
            end
        end else if (mk < 2 * W) begin
            if (mk == W && m_write) ref_mem[m_hw[9:0]] = m_data[15:0];
            mk++;
        end else if (mk == 2 * W) begin
            if (m_write) ref_mem[m_hw[9:0] + 10'd1] = m_data[31:16];
            else exp_rd = {ref_mem[m_hw[9:0] + 10'd1], ref_mem[m_hw[9:0]]};
            mk = (POSTED && m_write) ? -1 : 2 * W + 1;
        end else begin
            mk = -1;
        end
    end

    // Compare DUT outputs with the model in the middle of every cycle.
    always @(negedge clk) begin
        if (started && !rst) begin
            logic req;
            logic e_ready, e_we, e_oe;
            req = mem_r_en | mem_w_en;
            if (mk < 0) begin
                e_ready = !req || (POSTED && mem_w_en);
                e_we = 1'b1;
                e_oe = 1'b0;
            end else if (mk <= 2 * W) begin
                int ph, sub;
                ph  = (mk - 1) / W;
                sub = (mk - 1) % W;
                e_ready = (POSTED && m_write) ? !req : 1'b0;
                e_oe = m_write;
                e_we = !(m_write && sub < W - 1);
                checkOutput("sram_addr", 32'(sram_addr), m_hw + 32'(ph));
                checkOutput("sram_dq_out", 32'(sram_dq_out),
                            ph == 1 ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
            end else begin
                e_ready = 1'b1;
                e_we = 1'b1;
                e_oe = 1'b0;
            end
            checkOutput("ready", 32'(ready), 32'(e_ready));
            checkOutput("sram_we_n", 32'(sram_we_n), 32'(e_we));
            checkOutput("sram_dq_oe", 32'(sram_dq_oe), 32'(e_oe));
            if (e_ready) checkOutput("read_data", read_data, exp_rd);
        end
    end

    // Drive one request from cycle 0 and hold it until ready is seen; returns
    // the ready cycle, the bus contents on the first cycle of each phase, and
    // read_data at ready. Call just after an active edge.
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output int rc, output logic [31:0] rd,
                                 output logic [17:0] la, output logic [15:0] ld,
                                 output logic [17:0] ha, output logic [15:0] hd);
        mem_r_en = r;
        mem_w_en = w;
        alu_result = a;
        st_val = d;
        rc = -1;
        rd = 32'd0;
        la = '0; ld = '0; ha = '0; hd = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 1) begin la = sram_addr; ld = sram_dq_out; end
            if (c == W + 1) begin ha = sram_addr; hd = sram_dq_out; end
            if (ready) begin
                rc = c;
                rd = read_data;
                break;
            end
            @(posedge clk); #1;
        end
        if (rc < 0) checkOutput("ready_timeout", 32'hFFFF_FFFF, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int          rc, rc2;
    logic [31:0] rd, rd2;
    logic [17:0] la, ha;
    logic [15:0] ld, hd;

    initial begin
        rst = 1'b1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        alu_result = 32'd0; st_val = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;

        @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("reset_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("reset_read_data", read_data, 32'd0);
        checkOutput("reset_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;

        // Store 0xDEADBEEF at byte 1032 -> half-words 4 and 5.
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, rc, rd, la, ld, ha, hd);
`ifdef MEM_POSTED_WRITE_EN
        checkOutput("posted_write_ready_cycle", 32'(rc), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, rc, rd, la, ld, ha, hd);
        checkOutput("read_after_posted_cycle", 32'(rc), 32'd21);
`else
        checkOutput("write_ready_cycle", 32'(rc), 32'd11);
        checkOutput("write_lo_addr", 32'(la), 32'd4);
        checkOutput("write_lo_data", 32'(ld), 32'hBEEF);
        checkOutput("write_hi_addr", 32'(ha), 32'd5);
        checkOutput("write_hi_data", 32'(hd), 32'hDEAD);
        idle(2);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, rc, rd, la, ld, ha, hd);
        checkOutput("read_ready_cycle", 32'(rc), 32'd11);
        checkOutput("read_lo_addr", 32'(la), 32'd4);
`endif
        checkOutput("read_data_1032", rd, 32'hDEAD_BEEF);

        idle(20);
        @(negedge clk);
        checkOutput("idle_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("idle_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;

        // Both enables -> write; address past the SRAM size wraps to hw 8.
        applyStimulus(1'b1, 1'b1, BASE + (32'd1 << 19) + 32'd16, 32'h1234_5678,
                      rc, rd, la, ld, ha, hd);
        checkOutput("both_en_read_data_kept", rd, 32'hDEAD_BEEF);
`ifndef MEM_POSTED_WRITE_EN
        checkOutput("wrap_lo_addr", 32'(la), 32'd8);
`endif
        idle(1);
        applyStimulus(1'b1, 1'b0, 32'd1040, 32'd0, rc, rd, la, ld, ha, hd);
        checkOutput("wrap_read_back", rd, 32'h1234_5678);
        idle(2);

        // Reset in the HIGH phase of a write aborts it at once.
        mem_w_en = 1'b1; alu_result = 32'd1048; st_val = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        mem_w_en = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        @(negedge clk);
        checkOutput("high_phase_we_n_low", 32'(sram_we_n), 32'd0);
        checkOutput("high_phase_addr", 32'(sram_addr), 32'd13);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("abort_read_data", read_data, 32'd0);
        checkOutput("abort_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;

        // Read held through DONE, then a second read straight after.
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, rc, rd, la, ld, ha, hd);
        applyStimulus(1'b1, 1'b0, 32'd1036, 32'd0, rc2, rd2, la, ld, ha, hd);
        checkOutput("b2b_first_cycle", 32'(rc), 32'd11);
        checkOutput("b2b_first_data", rd, 32'hDEAD_BEEF);
        checkOutput("b2b_second_cycle", 32'(rc2), 32'd11);
        checkOutput("b2b_second_addr", 32'(la), 32'd6);
        checkOutput("b2b_second_data", rd2, 32'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Memory-stage controller that sequences the EXE/MEM pipeline register and the external 16-bit SRAM.
- Accepts MEM_R_EN/MEM_W_EN, the ALU address and ST_val from the EXE/MEM register outputs.
- Performs each 32-bit access as two 16-bit SRAM phases with programmable wait states.
- Drives `ready`; the pipeline uses freeze = ~ready to hold the EXE/MEM register and upstream stages until the access completes.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 5, cycles per 16-bit phase; legal range 2..15.
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- MEM_R_EN  input  1  load request from EXE/MEM register.
- MEM_W_EN  input  1  store request from EXE/MEM register.
- ALU_result  input  32  byte address, word aligned.
- ST_val  input  32  store data.
- read_data  output  32  load result; valid when ready=1 after a read.
- ready  output  1  1 = no stall; pipeline freeze = ~ready.
- SRAM_ADDR  output  ADDR_W  SRAM half-word address.
- SRAM_DQ_out  output  16  SRAM write data.
- SRAM_DQ_in  input  16  SRAM read data.
- SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the bus.
- SRAM_WE_N  output  1  SRAM write enable, active low.

Behaviour:
- State machine: IDLE, LOW, HIGH, DONE; 4-bit wait counter `cnt`.
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, cnt=0, read_data=0, latched addr/data/op=0.
  - SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
  - Reset mid-access aborts the access immediately; SRAM_WE_N is high from the next cycle.
- req = MEM_R_EN | MEM_W_EN. If both are asserted, the access is a write; read_data is unchanged.
- IDLE with req:
  - Latch off = ALU_result - BASE_ADDR (32-bit, wraps), ST_val, and op (write/read).
  - Next state LOW, cnt=0.
- LOW:
  - SRAM_ADDR = {off[ADDR_W:2], 1'b0}; SRAM_DQ_out = data[15:0].
  - cnt increments each cycle.
  - When cnt = WAIT_CYCLES-1: a read captures SRAM_DQ_in into read_data[15:0]; next state HIGH, cnt=0.
- HIGH:
  - SRAM_ADDR = {off[ADDR_W:2], 1'b1}; SRAM_DQ_out = data[31:16].
  - At cnt = WAIT_CYCLES-1: a read captures into read_data[31:16]; next state DONE.
- DONE: one cycle, then IDLE unconditionally. The request still asserted in DONE is never re-accepted.
- Writes:
  - SRAM_DQ_oe=1 throughout LOW/HIGH.
  - SRAM_WE_N=0 while cnt < WAIT_CYCLES-1 in LOW/HIGH; 1 on the last cycle of each phase (data/address hold).
- Reads: SRAM_WE_N=1, SRAM_DQ_oe=0.
- ready (combinational) = (state==IDLE && !req) || state==DONE.
- Latency: request first seen at cycle 0 → ready=0 for cycles 0..2·WAIT_CYCLES, ready=1 at cycle 2·WAIT_CYCLES+1 with read_data final.
- Address out of range (off ≥ 2^(ADDR_W+1)): upper bits are truncated and the access wraps. No error is raised.
- Input changes during LOW/HIGH are ignored because operands are latched.

Optional Feature:
- Macro: MEM_POSTED_WRITE_EN.
- Defined:
  - A write accepted in IDLE gives ready=1 in the same cycle; the pipeline is not frozen.
  - The write runs LOW→HIGH→IDLE in the background, skipping DONE.
  - During the background write, ready = !req. A new request waits and is accepted in the IDLE cycle after the write finishes.
  - Reads are not posted.
- Undefined: writes stall exactly like reads, as described in Behaviour.

Test Plan (WAIT_CYCLES=5, BASE_ADDR=1024):
- Write 0xDEADBEEF to 1032 → ready=0 for cycles 0..10, ready=1 at cycle 11. SRAM_ADDR=4 with DQ_out=0xBEEF, then SRAM_ADDR=5 with 0xDEAD. SRAM_WE_N low for 4 cycles per phase, high on the 5th. SRAM_DQ_oe=1 throughout.
- Read 1032 with SRAM model preloaded from the previous write → read_data=0xDEADBEEF at cycle 11 with ready=1. SRAM_WE_N stays 1.
- No request for 20 cycles → ready=1, SRAM_WE_N=1, SRAM_DQ_oe=0 throughout.
- Assert rst during HIGH of a write → next cycle state=IDLE, SRAM_WE_N=1, read_data=0. With MEM_R_EN=0 after reset, ready=1.
- Read held asserted through DONE, then a second read to 1036 → first completes at cycle 11, IDLE at cycle 12 accepts the second read (SRAM_ADDR=6), ready=1 again at cycle 23. No duplicate access.
- With MEM_POSTED_WRITE_EN: write then immediate read → ready=1 on the write cycle. The read stalls until the write ends (cycle 10), is accepted at cycle 11, and ready=1 at cycle 22.
